// File: rtl/fp16_pkg.sv
// Shared definitions for the fp16 datapath (divider, multiplier, classifier).
//   - format constants (bias, max exponent, canonical NaN, infinity magnitude)
//   - bit positions inside the 4-bit exception flag vector
//   - divider FSM state encoding
//   - unpacked operand record produced by fp16_classify
package fp16_pkg;

  localparam int          EXP_BIAS = 15;
  localparam int          EXP_MAX  = 31;
  localparam logic [15:0] QNAN     = 16'h7E00;
  localparam logic [14:0] INF_MAG  = 15'h7C00;

  // flags = {invalid, div_by_zero, overflow, underflow}
  localparam int FLG_INVALID = 3;
  localparam int FLG_DZ      = 2;
  localparam int FLG_OVF     = 1;
  localparam int FLG_UNF     = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  // man carries the hidden one; it is meaningless when is_zero/is_inf/is_nan
  typedef struct packed {
    logic        sign;
    logic [4:0]  exp;
    logic [10:0] man;
    logic        is_zero;
    logic        is_inf;
    logic        is_nan;
  } fp16_class_t;

endpackage

// File: rtl/fp16_classify.sv
// Combinational unpack of one binary16 operand.
//   x   : fp16 operand {sign, exp[4:0], frac[9:0]}
//   cls : sign, exponent, mantissa with hidden one, and zero/inf/nan class
// Subnormals (exp == 0, frac != 0) are treated as zero.
module fp16_classify
  import fp16_pkg::*;
(
  input  logic [15:0]  x,
  output fp16_class_t  cls
);

  logic [4:0] exp_field;
  logic [9:0] frac_field;

  assign exp_field  = x[14:10];
  assign frac_field = x[9:0];

  always_comb begin
    cls         = '0;
    cls.sign    = x[15];
    cls.exp     = exp_field;
    cls.man     = {1'b1, frac_field};
    cls.is_zero = (exp_field == 5'd0);
    cls.is_inf  = (exp_field == 5'(EXP_MAX)) && (frac_field == 10'd0);
    cls.is_nan  = (exp_field == 5'(EXP_MAX)) && (frac_field != 10'd0);
  end

endmodule

// File: rtl/fp16_divider.sv
// Iterative binary16 divider, result = a / b.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : operand handshake; in_ready only while idle
//   a, b                 : dividend, divisor (fp16)
//   out_valid / out_ready: result handshake; result/flags held until taken
//   result               : fp16 quotient
//   flags                : {invalid, div_by_zero, overflow, underflow}
// Special operands finish in one cycle. Normal operands run a restoring
// radix-2 division (one quotient bit per cycle), then one cycle of
// normalisation and round-to-nearest-even. Subnormals are flushed to zero
// on input and output.
module fp16_divider
  import fp16_pkg::*;
#(
  parameter int QBITS = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic [3:0]  flags
);

  // ---------------------------------------------------------------------
  // Operand classification (one classifier per operand)
  // ---------------------------------------------------------------------
  logic [1:0][15:0] opnd;
  fp16_class_t      cls [2];

  assign opnd[0] = a;
  assign opnd[1] = b;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_classify
      fp16_classify u_classify (
        .x   (opnd[gi]),
        .cls (cls[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t            state_reg, state_next;
  logic              sign_reg, sign_next;
  logic [4:0]        ea_reg, ea_next;
  logic [4:0]        eb_reg, eb_next;
  logic [10:0]       mb_reg, mb_next;
  // Remainder is below 2*mb after the shift, so 12 bits suffice.
  logic [11:0]       r_reg, r_next;
  logic [QBITS-1:0]  q_reg, q_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [15:0]       result_reg, result_next;
  logic [3:0]        flags_reg, flags_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      sign_reg   <= 1'b0;
      ea_reg     <= '0;
      eb_reg     <= '0;
      mb_reg     <= '0;
      r_reg      <= '0;
      q_reg      <= '0;
      cnt_reg    <= '0;
      result_reg <= 16'h0000;
      flags_reg  <= 4'b0000;
    end else begin
      state_reg  <= state_next;
      sign_reg   <= sign_next;
      ea_reg     <= ea_next;
      eb_reg     <= eb_next;
      mb_reg     <= mb_next;
      r_reg      <= r_next;
      q_reg      <= q_next;
      cnt_reg    <= cnt_next;
      result_reg <= result_next;
      flags_reg  <= flags_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;
  assign flags     = flags_reg;

  // ---------------------------------------------------------------------
  // One restoring division step
  // ---------------------------------------------------------------------
  logic        q_bit;
  logic [11:0] r_sub;

  always_comb begin
    q_bit = (r_reg >= {1'b0, mb_reg});
    r_sub = q_bit ? (r_reg - {1'b0, mb_reg}) : r_reg;
  end

  // ---------------------------------------------------------------------
  // Normalise and round (valid while in NORM)
  // ---------------------------------------------------------------------
  logic              int_bit;
  logic [9:0]        frac_pre;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [10:0]       frac_sum;
  logic signed [6:0] e_pre;
  logic signed [6:0] e_rnd;

  always_comb begin
    int_bit = q_reg[QBITS-1];
    if (int_bit) begin
      frac_pre = q_reg[12:3];
      guard    = q_reg[2];
      sticky   = (|q_reg[1:0]) | (r_reg != 12'd0);
    end else begin
      // Quotient of two normalised mantissas is >= 0.5, so q[12] is set here.
      frac_pre = q_reg[11:2];
      guard    = q_reg[1];
      sticky   = q_reg[0] | (r_reg != 12'd0);
    end
    e_pre = $signed({2'b00, ea_reg}) - $signed({2'b00, eb_reg})
          + (int_bit ? 7'sd15 : 7'sd14);
    round_up = guard && (sticky || frac_pre[0]);
    // A carry out of the fraction leaves frac_sum[9:0] at zero, which is
    // exactly the renormalised fraction of 2.0.
    frac_sum = {1'b0, frac_pre} + {10'd0, round_up};
    e_rnd    = e_pre + $signed({6'd0, frac_sum[10]});
  end

  // ---------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------
  logic op_sign;
  logic sp_invalid;
  logic sp_inf;
  logic sp_dz;
  logic sp_zero;

  always_comb begin
    op_sign    = cls[0].sign ^ cls[1].sign;
    sp_invalid = cls[0].is_nan || cls[1].is_nan
              || (cls[0].is_zero && cls[1].is_zero)
              || (cls[0].is_inf && cls[1].is_inf);
    sp_inf     = cls[0].is_inf;
    sp_dz      = cls[1].is_zero && !cls[0].is_inf;
    sp_zero    = cls[0].is_zero || cls[1].is_inf;
  end

  always_comb begin
    state_next  = state_reg;
    sign_next   = sign_reg;
    ea_next     = ea_reg;
    eb_next     = eb_reg;
    mb_next     = mb_reg;
    r_next      = r_reg;
    q_next      = q_reg;
    cnt_next    = cnt_reg;
    result_next = result_reg;
    flags_next  = flags_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          sign_next = op_sign;
          ea_next   = cls[0].exp;
          eb_next   = cls[1].exp;
          mb_next   = cls[1].man;
          r_next    = {1'b0, cls[0].man};
          q_next    = '0;
          cnt_next  = '0;
          if (sp_invalid) begin
            result_next              = QNAN;
            flags_next               = 4'b0000;
            flags_next[FLG_INVALID]  = 1'b1;
            state_next               = DONE;
          end else if (sp_inf) begin
            result_next = {op_sign, INF_MAG};
            flags_next  = 4'b0000;
            state_next  = DONE;
          end else if (sp_dz) begin
            result_next         = {op_sign, INF_MAG};
            flags_next          = 4'b0000;
            flags_next[FLG_DZ]  = 1'b1;
            state_next          = DONE;
          end else if (sp_zero) begin
            result_next = {op_sign, 15'd0};
            flags_next  = 4'b0000;
            state_next  = DONE;
          end else begin
            state_next = DIV;
          end
        end
      end

      DIV: begin
        q_next   = {q_reg[QBITS-2:0], q_bit};
        r_next   = {r_sub[10:0], 1'b0};
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == 4'(QBITS - 1)) begin
          state_next = NORM;
        end
      end

      NORM: begin
        flags_next = 4'b0000;
        if (e_rnd >= 7'sd31) begin
          result_next          = {sign_reg, INF_MAG};
          flags_next[FLG_OVF]  = 1'b1;
        end else if (e_rnd <= 7'sd0) begin
          result_next          = {sign_reg, 15'd0};
          flags_next[FLG_UNF]  = 1'b1;
        end else begin
          result_next = {sign_reg, e_rnd[4:0], frac_sum[9:0]};
        end
        state_next = DONE;
      end

      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fp16_divider.sv
module tb_fp16_divider;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  flags;

  int total;
  int bad;

  fp16_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic [15:0] res;
    logic [3:0]  flg;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Launch one operation; returns the result, flags, cycles from the input
  // handshake edge to out_valid, and the number of busy cycles where
  // in_ready was wrongly high. Returns with the DUT in DONE (or timed out).
  task automatic run_op(input logic [15:0] va, input logic [15:0] vb,
                        output logic [15:0] r, output logic [3:0] f,
                        output int lat, output int busy_bad);
    @(negedge clk);
    a = va;
    b = vb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    busy_bad = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_bad++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (in_ready) busy_bad++;
    r = result;
    f = flags;
  endtask

  vec_t vecs [13];

  initial begin
    logic [15:0] r;
    logic [3:0]  f;
    logic [15:0] held_r;
    logic [3:0]  held_f;
    int          lat;
    int          busy_bad;

    total = 0;
    bad = 0;

    vecs[0]  = '{16'h4600, 16'h4000, 16'h4200, 4'b0000, 16}; //  6 / 2
    vecs[1]  = '{16'hCA00, 16'h4400, 16'hC200, 4'b0000, 16}; // -12 / 4
    vecs[2]  = '{16'h3C00, 16'h4200, 16'h3555, 4'b0000, 16}; //  1 / 3, round down
    vecs[3]  = '{16'h4900, 16'h4200, 16'h42AB, 4'b0000, 16}; // 10 / 3, round up
    vecs[4]  = '{16'h3C00, 16'h4700, 16'h3092, 4'b0000, 16}; //  1 / 7
    vecs[5]  = '{16'h4500, 16'h0000, 16'h7C00, 4'b0100, 1};  //  5 / 0
    vecs[6]  = '{16'h0000, 16'h0000, 16'h7E00, 4'b1000, 1};  //  0 / 0
    vecs[7]  = '{16'h8000, 16'h4500, 16'h8000, 4'b0000, 1};  // -0 / 5
    vecs[8]  = '{16'h7BFF, 16'h3800, 16'h7C00, 4'b0010, 16}; // 65504 / 0.5
    vecs[9]  = '{16'h0400, 16'h4400, 16'h0000, 4'b0001, 16}; // 2^-14 / 4
    vecs[10] = '{16'h7E01, 16'h3C00, 16'h7E00, 4'b1000, 1};  // NaN / 1
    vecs[11] = '{16'h7C00, 16'hFC00, 16'h7E00, 4'b1000, 1};  // inf / -inf
    vecs[12] = '{16'hBC00, 16'h7C00, 16'h8000, 4'b0000, 1};  // -1 / inf

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = 16'h0000;
    b = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset result", {16'd0, result}, 32'h0000);
    check("reset flags", {28'd0, flags}, 32'h0);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].va, vecs[i].vb, r, f, lat, busy_bad);
      $display("op %0d: %h / %h -> %h flags %b latency %0d", i, vecs[i].va, vecs[i].vb, r, f, lat);
      check($sformatf("vec%0d result", i), {16'd0, r}, {16'd0, vecs[i].res});
      check($sformatf("vec%0d flags", i), {28'd0, f}, {28'd0, vecs[i].flg});
      check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d in_ready while busy", i), busy_bad, 0);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d out_valid after take", i), {31'd0, out_valid}, 32'd0);
      check($sformatf("vec%0d in_ready after take", i), {31'd0, in_ready}, 32'd1);
    end

    // Backpressure: hold the result for 5 cycles
    out_ready = 1'b0;
    run_op(16'h4600, 16'h4000, held_r, held_f, lat, busy_bad);
    $display("op bp: 4600 / 4000 -> %h flags %b latency %0d", held_r, held_f, lat);
    check("bp result", {16'd0, held_r}, 32'h4200);
    check("bp latency", lat, 16);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp hold%0d out_valid", k), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp hold%0d result", k), {16'd0, result}, 32'h4200);
      check($sformatf("bp hold%0d flags", k), {28'd0, flags}, 32'h0);
      check($sformatf("bp hold%0d in_ready", k), {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release in_ready", {31'd0, in_ready}, 32'd1);
    check("bp release out_valid", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of DIV
    @(negedge clk);
    a = 16'h4600;
    b = 16'h4000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("midrst busy in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    $display("op midrst: reset asserted during DIV");
    check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst result", {16'd0, result}, 32'h0000);
    check("midrst in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst no spurious out_valid", {31'd0, out_valid}, 32'd0);
    run_op(16'h4600, 16'h4000, r, f, lat, busy_bad);
    $display("op post-reset: 4600 / 4000 -> %h flags %b latency %0d", r, f, lat);
    check("postrst result", {16'd0, r}, 32'h4200);
    check("postrst flags", {28'd0, f}, 32'h0);
    check("postrst latency", lat, 16);
    @(posedge clk);
    #1;
    check("postrst in_ready", {31'd0, in_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
